vote_monitor: RTL and testbench

Parametrised, registered successor to the combinational fault voter. It counts failing votes among the enabled voters each cycle and compares the count against a runtime failure allowance. It raises a latched trip only after the over-threshold condition has persisted for a configurable number of cycles. It sits between the redundant-channel inputs and the system safe-state logic, and holds the trip until software acknowledges it.

---
 rtl/vote_pkg.sv | 22 ++
 rtl/vote_popcount.sv | 25 ++
 rtl/vote_monitor.sv | 171 +++++++++++++++++
 tb/tb_vote_monitor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// -----------------------------------------------------------------------------
// vote_pkg
// Shared definitions for the vote_monitor slice:
//   - vote_state_e : trip FSM state encoding (OK=0, PEND=1, TRIP=2)
//   - cnt_width(n) : width needed to hold a count of 0..n
//   - TRIP_CNT_W   : width of the saturating trip-entry counter
// -----------------------------------------------------------------------------
package vote_pkg;

    localparam int TRIP_CNT_W = 8;

    typedef enum logic [1:0] {
        VS_OK   = 2'd0,
        VS_PEND = 2'd1,
        VS_TRIP = 2'd2
    } vote_state_e;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vote_popcount.sv
// -----------------------------------------------------------------------------
// vote_popcount
// Purely combinational population count of the (already masked) vote vector.
// Ports:
//   i_votes  in  NUM_VOTERS  one bit per failing, participating voter
//   o_count  out CNT_W       number of set bits in i_votes
// -----------------------------------------------------------------------------
module vote_popcount
    import vote_pkg::*;
#(
    parameter int NUM_VOTERS = 8,
    parameter int CNT_W      = cnt_width(NUM_VOTERS)
) (
    input  logic [NUM_VOTERS-1:0] i_votes,
    output logic [CNT_W-1:0]      o_count
);

    always_comb begin
        o_count = '0;
        for (int unsigned i = 0; i < NUM_VOTERS; i++) begin
            o_count = o_count + CNT_W'(i_votes[i]);
        end
    end

endmodule

// File: rtl/vote_monitor.sv
// -----------------------------------------------------------------------------
// vote_monitor
// Registered fault voter: counts failing participating voters each cycle,
// compares against a runtime allowance and raises a latched trip once the
// over-threshold condition has persisted for PERSIST consecutive samples.
// The trip holds until clear_i is seen while the condition is gone.
//
// Optional feature macro: VOTE_HISTORY_EN (sticky per-voter fail history).
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   ena           in   global enable, 0 freezes all state
//   voter_i       in   per-voter fail flags
//   voter_mask_i  in   per-voter participation mask
//   threshold_i   in   tolerated failures (trip when count > threshold)
//   clear_i       in   trip acknowledge
//   fail_cnt_o    out  registered masked fail count
//   over_o        out  fail_cnt_o > threshold_i (combinational)
//   state_o       out  FSM state (OK=0, PEND=1, TRIP=2)
//   trip_o        out  high while in TRIP
//   trip_cnt_o    out  saturating count of TRIP entries
//   fail_hist_o   out  sticky fail history (0 when VOTE_HISTORY_EN undefined)
// -----------------------------------------------------------------------------
module vote_monitor
    import vote_pkg::*;
#(
    parameter int NUM_VOTERS = 8,
    parameter int PERSIST    = 3,
    parameter int CNT_W      = cnt_width(NUM_VOTERS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [NUM_VOTERS-1:0] voter_i,
    input  logic [NUM_VOTERS-1:0] voter_mask_i,
    input  logic [CNT_W-1:0]      threshold_i,
    input  logic                  clear_i,
    output logic [CNT_W-1:0]      fail_cnt_o,
    output logic                  over_o,
    output logic [1:0]            state_o,
    output logic                  trip_o,
    output logic [TRIP_CNT_W-1:0] trip_cnt_o,
    output logic [NUM_VOTERS-1:0] fail_hist_o
);

    logic [NUM_VOTERS-1:0] w_masked;
    logic [CNT_W-1:0]      w_count;
    logic [CNT_W-1:0]      r_fail_cnt;
    logic                  w_over;
    vote_state_e           r_state;
    vote_state_e           w_state_nxt;
    logic [3:0]            r_pcnt;
    logic [3:0]            w_pcnt_nxt;
    logic [TRIP_CNT_W-1:0] r_trip_cnt;
    logic                  w_enter_trip;

    assign w_masked = voter_i & voter_mask_i;

    vote_popcount #(
        .NUM_VOTERS (NUM_VOTERS),
        .CNT_W      (CNT_W)
    ) u_popcount (
        .i_votes (w_masked),
        .o_count (w_count)
    );

    // Over is judged on the registered count but the live threshold.
    assign w_over = (r_fail_cnt > threshold_i);

    // Count stage and trip-entry counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_cnt <= '0;
            r_trip_cnt <= '0;
        end else if (ena) begin
            r_fail_cnt <= w_count;
            if (w_enter_trip && (r_trip_cnt != '1)) begin
                r_trip_cnt <= r_trip_cnt + TRIP_CNT_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= VS_OK;
            r_pcnt  <= '0;
        end else if (ena) begin
            r_state <= w_state_nxt;
            r_pcnt  <= w_pcnt_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_pcnt_nxt  = r_pcnt;
        unique case (r_state)
            VS_OK: begin
                if (w_over) begin
                    if (PERSIST == 1) begin
                        w_state_nxt = VS_TRIP;
                        w_pcnt_nxt  = '0;
                    end else begin
                        w_state_nxt = VS_PEND;
                        w_pcnt_nxt  = 4'd1;
                    end
                end
            end
            VS_PEND: begin
                if (!w_over) begin
                    w_state_nxt = VS_OK;
                    w_pcnt_nxt  = '0;
                end else if ((r_pcnt + 4'd1) == 4'(PERSIST)) begin
                    w_state_nxt = VS_TRIP;
                    w_pcnt_nxt  = '0;
                end else begin
                    w_pcnt_nxt  = r_pcnt + 4'd1;
                end
            end
            VS_TRIP: begin
                // A clear while still over is ignored; the trip stays latched.
                if (clear_i && !w_over) begin
                    w_state_nxt = VS_OK;
                    w_pcnt_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = VS_OK;
                w_pcnt_nxt  = '0;
            end
        endcase
    end

    assign w_enter_trip = (r_state != VS_TRIP) && (w_state_nxt == VS_TRIP);

    // FSM outputs.
    always_comb begin
        fail_cnt_o = r_fail_cnt;
        over_o     = w_over;
        state_o    = r_state;
        trip_o     = (r_state == VS_TRIP);
        trip_cnt_o = r_trip_cnt;
    end

`ifdef VOTE_HISTORY_EN
    logic                  w_leave_clear;
    logic [NUM_VOTERS-1:0] r_fail_hist;

    assign w_leave_clear = (r_state == VS_TRIP) && (w_state_nxt == VS_OK);

    // Leaving TRIP via clear wipes history even if a vote fails on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_hist <= '0;
        end else if (ena) begin
            if (w_leave_clear) begin
                r_fail_hist <= '0;
            end else begin
                r_fail_hist <= r_fail_hist | w_masked;
            end
        end
    end

    assign fail_hist_o = r_fail_hist;
`else
    assign fail_hist_o = '0;
`endif

endmodule

// File: tb/tb_vote_monitor.sv
// -----------------------------------------------------------------------------
// tb_vote_monitor
// Directed stimulus for vote_monitor (NUM_VOTERS=8, PERSIST=3). The driver
// applies inputs 2 time units after a rising edge and queues the outputs
// expected after the following edge; a monitor checks 1 unit after each edge.
// -----------------------------------------------------------------------------
module tb_vote_monitor;

    localparam logic [1:0] OK   = 2'd0;
    localparam logic [1:0] PEND = 2'd1;
    localparam logic [1:0] TRIP = 2'd2;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] voter_i;
    logic [7:0] voter_mask_i;
    logic [3:0] threshold_i;
    logic       clear_i;
    logic [3:0] fail_cnt_o;
    logic       over_o;
    logic [1:0] state_o;
    logic       trip_o;
    logic [7:0] trip_cnt_o;
    logic [7:0] fail_hist_o;

    vote_monitor #(
        .NUM_VOTERS (8),
        .PERSIST    (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .voter_i      (voter_i),
        .voter_mask_i (voter_mask_i),
        .threshold_i  (threshold_i),
        .clear_i      (clear_i),
        .fail_cnt_o   (fail_cnt_o),
        .over_o       (over_o),
        .state_o      (state_o),
        .trip_o       (trip_o),
        .trip_cnt_o   (trip_cnt_o),
        .fail_hist_o  (fail_hist_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cnt;
        logic       over;
        logic [1:0] st;
        logic       trip;
        logic [7:0] tc;
        logic [7:0] hist;
        int         id;
    } exp_t;

    exp_t q[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   step_id = 0;

    function automatic logic [7:0] hx(input logic [7:0] h);
`ifdef VOTE_HISTORY_EN
        return h;
`else
        return h & 8'h00;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] v, input logic [7:0] m, input logic [3:0] thr,
                        input logic clr, input logic en, input logic [3:0] e_cnt,
                        input logic [1:0] e_st, input logic [7:0] e_tc, input logic [7:0] e_hist);
        exp_t e;
        @(posedge clk);
        #2;
        voter_i      = v;
        voter_mask_i = m;
        threshold_i  = thr;
        clear_i      = clr;
        ena          = en;
        step_id++;
        e.cnt  = e_cnt;
        e.over = (e_cnt > thr);
        e.st   = e_st;
        e.trip = (e_st == TRIP);
        e.tc   = e_tc;
        e.hist = hx(e_hist);
        e.id   = step_id;
        q.push_back(e);
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_cmp++;
                if ({fail_cnt_o, over_o, state_o, trip_o, trip_cnt_o, fail_hist_o} !==
                    {e.cnt, e.over, e.st, e.trip, e.tc, e.hist}) begin
                    n_err++;
                    $display("FAIL step%0d: got cnt=%0d over=%0b st=%0d trip=%0b tc=%0d hist=%h expected cnt=%0d over=%0b st=%0d trip=%0b tc=%0d hist=%h",
                             e.id, fail_cnt_o, over_o, state_o, trip_o, trip_cnt_o, fail_hist_o,
                             e.cnt, e.over, e.st, e.trip, e.tc, e.hist);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin : driver
        int tc;
        int tp;
        rst_n        = 1'b0;
        ena          = 1'b1;
        voter_i      = 8'h00;
        voter_mask_i = 8'hFF;
        threshold_i  = 4'd2;
        clear_i      = 1'b0;
        #1;
        chk("reset_cnt",   32'(fail_cnt_o),  0);
        chk("reset_state", 32'(state_o),     0);
        chk("reset_trip",  32'(trip_o),      0);
        chk("reset_tc",    32'(trip_cnt_o),  0);
        chk("reset_hist",  32'(fail_hist_o), 0);
        chk("reset_over",  32'(over_o),      0);
        #11;
        rst_n = 1'b1;

        // Basic trip, 1-cycle count latency, PERSIST=3
        step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, OK,   8'd1 - 8'd1, 8'h07);
        step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, PEND, 8'd0, 8'h07);
        step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, PEND, 8'd0, 8'h07);
        step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, TRIP, 8'd1, 8'h07);
        // Clear while over is ignored; clear with over gone returns to OK
        step(8'h07, 8'hFF, 4'd2, 1, 1, 4'd3, TRIP, 8'd1, 8'h07);
        step(8'h00, 8'hFF, 4'd2, 1, 1, 4'd0, TRIP, 8'd1, 8'h07);
        step(8'h00, 8'hFF, 4'd2, 1, 1, 4'd0, OK,   8'd1, 8'h00);

        // Persistence break
        step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, OK,   8'd1, 8'h07);
        step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, PEND, 8'd1, 8'h07);
        step(8'h01, 8'hFF, 4'd2, 0, 1, 4'd1, PEND, 8'd1, 8'h07);
        step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, OK,   8'd1, 8'h07);
        step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, PEND, 8'd1, 8'h07);
        step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, PEND, 8'd1, 8'h07);
        step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, TRIP, 8'd2, 8'h07);
        step(8'h00, 8'hFF, 4'd2, 1, 1, 4'd0, TRIP, 8'd2, 8'h07);
        step(8'h00, 8'hFF, 4'd2, 1, 1, 4'd0, OK,   8'd2, 8'h00);

        // Masking
        step(8'hFF, 8'h0F, 4'd3, 0, 1, 4'd4, OK,   8'd2, 8'h0F);
        step(8'hFF, 8'h0F, 4'd3, 0, 1, 4'd4, PEND, 8'd2, 8'h0F);
        step(8'hFF, 8'h0F, 4'd3, 0, 1, 4'd4, PEND, 8'd2, 8'h0F);
        step(8'hFF, 8'h0F, 4'd3, 0, 1, 4'd4, TRIP, 8'd3, 8'h0F);
        step(8'h00, 8'h0F, 4'd3, 1, 1, 4'd0, TRIP, 8'd3, 8'h0F);
        step(8'h00, 8'h0F, 4'd3, 1, 1, 4'd0, OK,   8'd3, 8'h00);

        // Threshold = NUM_VOTERS never trips, even with every voter failing
        for (int i = 0; i < 5; i++) begin
            step(8'hFF, 8'hFF, 4'd8, 0, 1, 4'd8, OK, 8'd3, 8'hFF);
        end
        step(8'h00, 8'hFF, 4'd8, 0, 1, 4'd0, OK, 8'd3, 8'hFF);

        // Enable freeze in PEND, then resume from held persist count
        step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, OK,   8'd3, 8'hFF);
        step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, PEND, 8'd3, 8'hFF);
        step(8'hFF, 8'hFF, 4'd2, 0, 0, 4'd3, PEND, 8'd3, 8'hFF);
        step(8'h00, 8'hFF, 4'd2, 0, 0, 4'd3, PEND, 8'd3, 8'hFF);
        step(8'hAA, 8'hFF, 4'd5, 0, 0, 4'd3, PEND, 8'd3, 8'hFF);
        step(8'h07, 8'hFF, 4'd2, 0, 0, 4'd3, PEND, 8'd3, 8'hFF);
        step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, PEND, 8'd3, 8'hFF);
        step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, TRIP, 8'd4, 8'hFF);

        // Asynchronous reset between edges while in TRIP
        @(posedge clk);
        #4;
        chk("pre_rst_trip", 32'(trip_o), 1);
        rst_n   = 1'b0;
        voter_i = 8'h00;
        clear_i = 1'b0;
        ena     = 1'b1;
        #1;
        chk("async_rst_trip",  32'(trip_o),      0);
        chk("async_rst_tc",    32'(trip_cnt_o),  0);
        chk("async_rst_cnt",   32'(fail_cnt_o),  0);
        chk("async_rst_state", 32'(state_o),     0);
        chk("async_rst_hist",  32'(fail_hist_o), 0);
        #2;
        rst_n = 1'b1;

        // Trip counter saturation over 300 trip/clear cycles
        for (int i = 1; i <= 300; i++) begin
            tp = (i - 1 > 255) ? 255 : i - 1;
            tc = (i > 255) ? 255 : i;
            step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, OK,   8'(tp), 8'h07);
            step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, PEND, 8'(tp), 8'h07);
            step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, PEND, 8'(tp), 8'h07);
            step(8'h07, 8'hFF, 4'd2, 0, 1, 4'd3, TRIP, 8'(tc), 8'h07);
            step(8'h00, 8'hFF, 4'd2, 1, 1, 4'd0, TRIP, 8'(tc), 8'h07);
            step(8'h00, 8'hFF, 4'd2, 1, 1, 4'd0, OK,   8'(tc), 8'h00);
        end

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drain", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
